// File: rtl/axi4_sram_rfifo.sv
// AXI4 R-channel FIFO between an SRAM controller and the read-data consumer.
// Optional zero-latency bypass when empty: define AXI4_SRAM_RFIFO_BYPASS_EN.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif

module axi4_sram_rfifo #(
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_rvalid_i,
  output logic                           s_rready_o,
  input  logic [`AXI4_DATA_WIDTH-1:0]    s_rdata_i,
  input  logic [`AXI4_ID_WIDTH-1:0]      s_rid_i,
  input  logic [1:0]                     s_rresp_i,
  input  logic                           s_rlast_i,
  output logic                           m_rvalid_o,
  input  logic                           m_rready_i,
  output logic [`AXI4_DATA_WIDTH-1:0]    m_rdata_o,
  output logic [`AXI4_ID_WIDTH-1:0]      m_rid_o,
  output logic [1:0]                     m_rresp_o,
  output logic                           m_rlast_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic [$clog2(DEPTH):0]         burst_avail_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = `AXI4_DATA_WIDTH;
  localparam int IW = `AXI4_ID_WIDTH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  // Handshake: a beat moves on any rising edge where valid and ready are both
  // high; valid never waits on ready, and the payload is held until accepted.

  beat_t       mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] burst_q, burst_d;

  beat_t s_beat;
  beat_t head;
  beat_t m_beat;
  logic  empty;
  logic  full;
  logic  bypass;
  logic  push;
  logic  pop;
  logic  push_last;
  logic  pop_last;

  assign s_beat = {s_rdata_i, s_rid_i, s_rresp_i, s_rlast_i};
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign s_rready_o = ~full;

`ifdef AXI4_SRAM_RFIFO_BYPASS_EN
  assign bypass = empty & s_rvalid_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed beat that is taken immediately never enters the buffer.
  assign push = s_rvalid_i & s_rready_o & ~(bypass & m_rready_i);
  assign pop  = ~empty & m_rready_i;

  assign push_last = push & s_rlast_i;
  assign pop_last  = pop & head.last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    burst_d  = burst_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_last && !pop_last) begin
      burst_d = burst_q + 1'b1;
    end else if (!push_last && pop_last) begin
      burst_d = burst_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      burst_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      burst_q  <= burst_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_beat;
    end
  end

  always_comb begin
    m_beat = '0;
    if (bypass) begin
      m_beat = s_beat;
    end else if (!empty) begin
      m_beat = head;
    end
  end

  assign m_rvalid_o    = ~empty | bypass;
  assign m_rdata_o     = m_beat.data;
  assign m_rid_o       = m_beat.id;
  assign m_rresp_o     = m_beat.resp;
  assign m_rlast_o     = m_beat.last;
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign burst_avail_o = burst_q;

endmodule

// File: tb/tb_axi4_sram_rfifo.sv
// Directed bench for axi4_sram_rfifo: a DEPTH=4 instance for flow control and
// ordering, a DEPTH=8 instance on the same inputs for two stored bursts.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif

module tb_axi4_sram_rfifo;
  localparam int DW = `AXI4_DATA_WIDTH;
  localparam int IW = `AXI4_ID_WIDTH;

  logic          clk;
  logic          rst;
  logic          s_rvalid;
  logic [DW-1:0] s_rdata;
  logic [IW-1:0] s_rid;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          m_rready;

  logic          s_rready;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [IW-1:0] m_rid;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic [2:0]    count;
  logic [2:0]    burst;

  logic          d8_s_rready;
  logic          d8_m_rvalid;
  logic [DW-1:0] d8_m_rdata;
  logic [IW-1:0] d8_m_rid;
  logic [1:0]    d8_m_rresp;
  logic          d8_m_rlast;
  logic [3:0]    d8_count;
  logic [3:0]    d8_burst;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  axi4_sram_rfifo #(.DEPTH(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_rvalid_i(s_rvalid), .s_rready_o(s_rready), .s_rdata_i(s_rdata),
    .s_rid_i(s_rid), .s_rresp_i(s_rresp), .s_rlast_i(s_rlast),
    .m_rvalid_o(m_rvalid), .m_rready_i(m_rready), .m_rdata_o(m_rdata),
    .m_rid_o(m_rid), .m_rresp_o(m_rresp), .m_rlast_o(m_rlast),
    .count_o(count), .burst_avail_o(burst)
  );

  axi4_sram_rfifo #(.DEPTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst),
    .s_rvalid_i(s_rvalid), .s_rready_o(d8_s_rready), .s_rdata_i(s_rdata),
    .s_rid_i(s_rid), .s_rresp_i(s_rresp), .s_rlast_i(s_rlast),
    .m_rvalid_o(d8_m_rvalid), .m_rready_i(m_rready), .m_rdata_o(d8_m_rdata),
    .m_rid_o(d8_m_rid), .m_rresp_o(d8_m_rresp), .m_rlast_o(d8_m_rlast),
    .count_o(d8_count), .burst_avail_o(d8_burst)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst = 1'b1;
    s_rvalid = 1'b0;
    m_rready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // driver
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [IW-1:0] id,
                       input logic [1:0] rs, input logic l);
    s_rvalid = v;
    s_rdata  = d;
    s_rid    = id;
    s_rresp  = rs;
    s_rlast  = l;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int got;
    int idx;
    logic prev_stall;
    logic [DW-1:0] held;

    rst = 1'b1;
    drive(1'b0, '0, '0, 2'd0, 1'b0);
    m_rready = 1'b0;

    // single beat after reset
    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_burst", 64'(burst), 64'd0);
    chk("rst_mvalid", 64'(m_rvalid), 64'd0);
    chk("rst_mdata", 64'(m_rdata), 64'd0);
    chk("rst_sready", 64'(s_rready), 64'd1);
    drive(1'b1, DW'(32'hA5), IW'(3), 2'd0, 1'b1);
    m_rready = 1'b1;
    #1;
`ifdef AXI4_SRAM_RFIFO_BYPASS_EN
    chk("t1_bypass_valid", 64'(m_rvalid), 64'd1);
    chk("t1_bypass_data", 64'(m_rdata), 64'hA5);
`else
    chk("t1_no_bypass", 64'(m_rvalid), 64'd0);
`endif
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
`ifdef AXI4_SRAM_RFIFO_BYPASS_EN
    chk("t1_bp_count", 64'(count), 64'd0);
    chk("t1_bp_burst", 64'(burst), 64'd0);
`else
    chk("t1_valid", 64'(m_rvalid), 64'd1);
    chk("t1_data", 64'(m_rdata), 64'hA5);
    chk("t1_id", 64'(m_rid), 64'd3);
    chk("t1_last", 64'(m_rlast), 64'd1);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_burst", 64'(burst), 64'd1);
`endif
    @(negedge clk);
    #1;
    chk("t1_count_end", 64'(count), 64'd0);
    chk("t1_valid_end", 64'(m_rvalid), 64'd0);
    chk("t1_data_zero", 64'(m_rdata), 64'd0);

    // fill DEPTH=4, fifth beat held upstream, pop-only when full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(16 + i), IW'(1), 2'd0, 1'b0);
      #1;
      chk("t2_sready_fill", 64'(s_rready), 64'd1);
      @(negedge clk);
    end
    drive(1'b1, DW'(20), IW'(1), 2'd0, 1'b0);
    #1;
    chk("t2_sready_full", 64'(s_rready), 64'd0);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_head", 64'(m_rdata), 64'd16);
    m_rready = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_count_pop", 64'(count), 64'd3);
    chk("t3_sready", 64'(s_rready), 64'd1);
    chk("t3_head", 64'(m_rdata), 64'd17);
    m_rready = 1'b0;
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    chk("t3_count_push", 64'(count), 64'd4);
    m_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_valid", 64'(m_rvalid), 64'd1);
      chk("t2_drain_data", 64'(m_rdata), 64'(17 + k));
      @(negedge clk);
      #1;
    end
    chk("t2_empty", 64'(count), 64'd0);
    chk("t2_empty_valid", 64'(m_rvalid), 64'd0);

    // two 3-beat bursts into DEPTH=8
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, DW'(32 + i), IW'(i / 3), 2'd0, (i == 2 || i == 5));
      @(negedge clk);
    end
    s_rvalid = 1'b0;
    #1;
    chk("t4_count8", 64'(d8_count), 64'd6);
    chk("t4_burst8", 64'(d8_burst), 64'd2);
    m_rready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t4_data8", 64'(d8_m_rdata), 64'(32 + k));
      chk("t4_burst_dec", 64'(d8_burst), (k <= 2) ? 64'd2 : 64'd1);
      @(negedge clk);
      #1;
    end
    chk("t4_burst_end", 64'(d8_burst), 64'd0);
    chk("t4_count_end", 64'(d8_count), 64'd0);

    // 10 beats, random downstream stalls, wrap and stability
    do_reset();
    got = 0;
    idx = 0;
    prev_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      if (prev_stall) chk("t5_stable", 64'(m_rdata), 64'(held));
      m_rready = 1'($urandom_range(0, 1));
      drive(idx < 10, DW'(idx), IW'(idx % 4), 2'd0, (idx % 3) == 2);
      #1;
      if (s_rvalid && s_rready) begin
        exp_q.push_back(DW'(idx));
        idx++;
      end
      if (m_rvalid && m_rready) begin
        if (exp_q.size() == 0) chk("t5_unexpected_pop", 64'(m_rdata), 64'hDEAD);
        else chk("t5_order", 64'(m_rdata), 64'(exp_q.pop_front()));
        got++;
      end
      prev_stall = m_rvalid && !m_rready;
      held = m_rdata;
      @(negedge clk);
    end
    s_rvalid = 1'b0;
    chk("t5_received", 64'(got), 64'd10);

    // reset with entries stored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(40 + i), IW'(2), 2'd0, i == 1);
      @(negedge clk);
    end
    s_rvalid = 1'b0;
    #1;
    chk("t6_count_pre", 64'(count), 64'd3);
    chk("t6_burst_pre", 64'(burst), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_mvalid", 64'(m_rvalid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_burst", 64'(burst), 64'd0);
    chk("t6_sready", 64'(s_rready), 64'd1);
    chk("t6_mdata", 64'(m_rdata), 64'd0);
    @(negedge clk);
    #1;
    chk("t6_still_empty", 64'(m_rvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
